spsram_fifo: RTL and testbench

//   Synchronous FIFO controller that stores its payload in an external

---
 rtl/spsram_fifo.sv | 180 ++++++++++++++++++
 tb/tb_spsram_fifo.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spsram_fifo.sv
// -----------------------------------------------------------------------------
// spsram_fifo
//
// Synchronous FIFO controller that keeps its payload in an external
// single-port SRAM macro (en/wen/addr/din, read data one cycle after a read).
// Words flow through three stages, strictly in order:
//   write-hold register (WH) -> SRAM ring -> 2-entry output buffer (OB)
// The single SRAM port is shared between draining WH into the ring and
// refilling OB from the ring; reads win when both want the port.
//
// Parameters
//   W  data word width, must match the SRAM word width
//   N  SRAM depth in words (N >= 2, any value, not only powers of two)
//
// Ports
//   clk        clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   push_vld   upstream word valid
//   push_data  upstream word
//   push_rdy   word accepted when push_vld & push_rdy
//   pop_vld    head word valid
//   pop_data   head word
//   pop_rdy    head consumed when pop_vld & pop_rdy
//   count      total words held (WH + SRAM + read in flight + OB), max N+3
//   sram_en    SRAM access enable
//   sram_wen   1 = write, 0 = read (meaningful only while sram_en)
//   sram_addr  SRAM address
//   sram_din   SRAM write data
//   sram_dout  SRAM read data, valid one cycle after a read
// -----------------------------------------------------------------------------
module spsram_fifo #(
  parameter int W = 32,
  parameter int N = 128
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_vld,
  input  logic [W-1:0]            push_data,
  output logic                    push_rdy,
  output logic                    pop_vld,
  output logic [W-1:0]            pop_data,
  input  logic                    pop_rdy,
  output logic [$clog2(N+4)-1:0]  count,
  output logic                    sram_en,
  output logic                    sram_wen,
  output logic [$clog2(N)-1:0]    sram_addr,
  output logic [W-1:0]            sram_din,
  input  logic [W-1:0]            sram_dout
);

  localparam int AW = $clog2(N);
  localparam int SW = $clog2(N + 1);
  localparam int CW = $clog2(N + 4);

  // Write-hold register
  logic          wh_vld_q, wh_vld_d;
  logic [W-1:0]  wh_data_q, wh_data_d;

  // SRAM ring bookkeeping
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [SW-1:0] sram_cnt_q, sram_cnt_d;
  logic          rd_inflight_q, rd_inflight_d;

  // Output buffer: entry 0 is always the head
  logic [W-1:0]  ob_data_q [2];
  logic [W-1:0]  ob_data_d [2];
  logic [1:0]    ob_cnt_q, ob_cnt_d;

  logic          rd_go;
  logic          wr_go;
  logic          push_fire;
  logic          pop_fire;
  logic [2:0]    ob_pending;

  // ---------------------------------------------------------------------------
  // Port arbitration, from registered state only
  // ---------------------------------------------------------------------------
  // A read may only be launched if OB has a free slot counting the read that
  // is already on its way back.
  assign ob_pending = {1'b0, ob_cnt_q} + {2'b00, rd_inflight_q};
  assign rd_go      = (sram_cnt_q != '0) && (ob_pending < 3'd2);
  assign wr_go      = wh_vld_q && (sram_cnt_q != SW'(N)) && !rd_go;

  assign sram_en    = rd_go || wr_go;
  assign sram_wen   = wr_go;
  assign sram_addr  = wr_go ? wr_ptr_q : rd_ptr_q;
  assign sram_din   = wh_data_q;

  // ---------------------------------------------------------------------------
  // Handshakes and status
  // ---------------------------------------------------------------------------
  // WH can take a new word when it is empty or is being written this cycle.
  // rst_n gates it so nothing is advertised while reset is asserted.
  assign push_rdy  = rst_n && (!wh_vld_q || wr_go);
  assign pop_vld   = (ob_cnt_q != 2'd0);
  assign pop_data  = ob_data_q[0];

  assign push_fire = push_vld && push_rdy;
  assign pop_fire  = pop_vld && pop_rdy;

  assign count = CW'(wh_vld_q) + CW'(sram_cnt_q) + CW'(rd_inflight_q) + CW'(ob_cnt_q);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    wh_vld_d      = wh_vld_q;
    wh_data_d     = wh_data_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    sram_cnt_d    = sram_cnt_q;
    rd_inflight_d = rd_go;
    ob_data_d     = ob_data_q;
    ob_cnt_d      = ob_cnt_q;

    // WH empties when written to SRAM, refills on an accepted push.
    if (wr_go) begin
      wh_vld_d = 1'b0;
    end
    if (push_fire) begin
      wh_vld_d  = 1'b1;
      wh_data_d = push_data;
    end

    // Ring pointers wrap explicitly, N need not be a power of two.
    if (wr_go) begin
      wr_ptr_d   = (wr_ptr_q == AW'(N - 1)) ? '0 : wr_ptr_q + 1'b1;
      sram_cnt_d = sram_cnt_q + 1'b1;
    end else if (rd_go) begin
      rd_ptr_d   = (rd_ptr_q == AW'(N - 1)) ? '0 : rd_ptr_q + 1'b1;
      sram_cnt_d = sram_cnt_q - 1'b1;
    end

    // Pop frees the head first, so returning read data lands in the slot
    // that is the tail after the pop.
    if (pop_fire) begin
      ob_data_d[0] = ob_data_q[1];
      ob_cnt_d     = ob_cnt_q - 2'd1;
    end
    if (rd_inflight_q) begin
      ob_data_d[ob_cnt_d[0]] = sram_dout;
      ob_cnt_d               = ob_cnt_d + 2'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Control state: reset to empty
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wh_vld_q      <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      sram_cnt_q    <= '0;
      rd_inflight_q <= 1'b0;
      ob_cnt_q      <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      wh_vld_q      <= wh_vld_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      sram_cnt_q    <= sram_cnt_d;
      rd_inflight_q <= rd_inflight_d;
      ob_cnt_q      <= ob_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Payload storage
  // ---------------------------------------------------------------------------
  // NOTE: data registers are not reset; their contents are only observed
  // while the matching valid/count says so, which keeps them plain flops.
  always_ff @(posedge clk) begin
    wh_data_q <= wh_data_d;
    ob_data_q <= ob_data_d;
  end

endmodule

// File: tb/tb_spsram_fifo.sv
// -----------------------------------------------------------------------------
// tb_spsram_fifo
//
// Directed bench for spsram_fifo with N = 5 (non power of two, so pointer
// wraps at 4 -> 0 are exercised often). A behavioural single-port SRAM
// completes the loop. A queue holds every accepted word; every pop is compared
// against its head and count is compared against its size after each edge.
// -----------------------------------------------------------------------------
module tb_spsram_fifo;

  localparam int W  = 32;
  localparam int N  = 5;
  localparam int AW = $clog2(N);
  localparam int CW = $clog2(N + 4);

  logic           clk;
  logic           rst_n;
  logic           push_vld;
  logic [W-1:0]   push_data;
  logic           push_rdy;
  logic           pop_vld;
  logic [W-1:0]   pop_data;
  logic           pop_rdy;
  logic [CW-1:0]  count;
  logic           sram_en;
  logic           sram_wen;
  logic [AW-1:0]  sram_addr;
  logic [W-1:0]   sram_din;
  logic [W-1:0]   sram_dout;

  spsram_fifo #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_vld  (push_vld),
    .push_data (push_data),
    .push_rdy  (push_rdy),
    .pop_vld   (pop_vld),
    .pop_data  (pop_data),
    .pop_rdy   (pop_rdy),
    .count     (count),
    .sram_en   (sram_en),
    .sram_wen  (sram_wen),
    .sram_addr (sram_addr),
    .sram_din  (sram_din),
    .sram_dout (sram_dout)
  );

  // Behavioural single-port SRAM, one-cycle read latency
  logic [W-1:0] mem [8];
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_wen) mem[sram_addr] <= sram_din;
      else          sram_dout      <= mem[sram_addr];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_errors = 0;
  int            n_pops   = 0;
  logic          prev_read;
  logic [W-1:0]  sb [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: log handshakes against the model, advance, check count.
  task automatic cycle();
    logic [W-1:0] exp;
    if (sram_en) check("sram_addr_range", 64'(sram_addr < AW'(N)), 64'd1);
    if (push_vld && push_rdy) sb.push_back(push_data);
    if (pop_vld && pop_rdy) begin
      check("pop_model_nonempty", 64'(sb.size() != 0), 64'd1);
      exp = (sb.size() != 0) ? sb.pop_front() : 'x;
      check("pop_data_order", pop_data, exp);
      n_pops++;
    end
    prev_read = sram_en && !sram_wen;
    @(posedge clk);
    #1;
    check("count_vs_model", count, sb.size());
  endtask

  task automatic push_word(input logic [W-1:0] d);
    int g;
    push_vld  = 1'b1;
    push_data = d;
    g = 0;
    while (!push_rdy && g < 20) begin
      cycle();
      g++;
    end
    check("push_rdy_within_bound", push_rdy, 1'b1);
    cycle();
    push_vld = 1'b0;
  endtask

  task automatic drain();
    int g;
    push_vld = 1'b0;
    pop_rdy  = 1'b1;
    g = 0;
    while (sb.size() != 0 && g < 200) begin
      cycle();
      g++;
    end
    check("drain_count_zero", count, 0);
    check("drain_pop_vld_low", pop_vld, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           p0;
    int           pushed;
    int           g;
    logic [W-1:0] val;
    logic         fire;

    rst_n     = 1'b0;
    push_vld  = 1'b0;
    push_data = '0;
    pop_rdy   = 1'b0;
    prev_read = 1'b0;
    #1;
    check("rst_pop_vld",  pop_vld,  1'b0);
    check("rst_count",    count,    0);
    check("rst_sram_en",  sram_en,  1'b0);
    check("rst_push_rdy", push_rdy, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_push_rdy", push_rdy, 1'b1);

    // 1. Single word latency: accept at E0, pop_vld after E3
    push_vld  = 1'b1;
    push_data = 32'hA5;
    pop_rdy   = 1'b1;
    cycle();                                  // E0
    push_vld = 1'b0;
    check("t1_count_after_accept", count, 1);
    check("t1_pop_vld_e0", pop_vld, 1'b0);
    cycle();                                  // E1
    check("t1_pop_vld_e1", pop_vld, 1'b0);
    cycle();                                  // E2
    check("t1_pop_vld_e2", pop_vld, 1'b0);
    cycle();                                  // E3
    check("t1_pop_vld_e3", pop_vld, 1'b1);
    check("t1_pop_data",   pop_data, 32'hA5);
    check("t1_count_e3",   count, 1);
    cycle();
    check("t1_count_after_pop", count, 0);
    check("t1_pop_vld_after_pop", pop_vld, 1'b0);

    // 2. Fill to N+3 with no pops, then drain in order
    pop_rdy = 1'b0;
    for (int i = 0; i < N + 3; i++) push_word(W'(i));
    push_vld  = 1'b1;
    push_data = 32'hDEAD;
    repeat (3) cycle();
    check("t2_full_push_rdy", push_rdy, 1'b0);
    check("t2_full_count",    count, N + 3);
    p0 = n_pops;
    drain();
    check("t2_pops", n_pops - p0, N + 3);

    // 3. Interleave 40 words keeping occupancy around 4..6
    p0     = n_pops;
    val    = 32'h300;
    pushed = 0;
    pop_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_word(val);
      val++;
      pushed++;
    end
    g = 0;
    while (pushed < 40 && g < 400) begin
      push_vld  = 1'b1;
      push_data = val;
      pop_rdy   = (sb.size() >= 4);
      fire      = push_rdy;
      cycle();
      if (fire) begin
        val++;
        pushed++;
      end
      g++;
    end
    check("t3_pushed_40", pushed, 40);
    drain();
    check("t3_pops", n_pops - p0, 40);

    // 4. Continuous push and pop: one word per two cycles
    p0      = n_pops;
    val     = 32'h1000;
    push_vld = 1'b1;
    pop_rdy  = 1'b1;
    repeat (202) begin
      push_data = val;
      fire      = push_rdy;
      cycle();
      if (fire) val++;
    end
    check("t4_throughput_ge_99", 64'((n_pops - p0) >= 99), 64'd1);
    drain();

    // 5. Reset with count = 5 and a read in flight
    pop_rdy = 1'b0;
    for (int i = 0; i < 5; i++) push_word(32'h500 + W'(i));
    repeat (4) cycle();
    push_vld  = 1'b1;
    push_data = 32'h55;
    pop_rdy   = 1'b1;
    cycle();
    push_vld = 1'b0;
    pop_rdy  = 1'b0;
    cycle();
    check("t5_read_in_flight", prev_read, 1'b1);
    check("t5_count_before_rst", count, 5);
    #4;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("t5_rst_pop_vld",  pop_vld,  1'b0);
    check("t5_rst_count",    count,    0);
    check("t5_rst_sram_en",  sram_en,  1'b0);
    check("t5_rst_push_rdy", push_rdy, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    p0      = n_pops;
    pop_rdy = 1'b1;
    push_word(32'h11);
    g = 0;
    while (sb.size() != 0 && g < 10) begin
      cycle();
      g++;
    end
    check("t5_first_pop_seen", n_pops - p0, 1);

    // 6. Stalled head: data stable, no SRAM reads with OB full
    pop_rdy = 1'b0;
    push_word(32'h61);
    push_word(32'h62);
    push_word(32'h63);
    repeat (4) cycle();
    repeat (10) begin
      check("t6_pop_vld",    pop_vld,  1'b1);
      check("t6_pop_data",   pop_data, 32'h61);
      check("t6_no_read",    64'(sram_en && !sram_wen), 64'd0);
      cycle();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
